// File: rtl/scudsp_dma_seq.sv
// SCU DSP DMA transfer sequencer: moves 32-bit words between the D0 bus and the DSP
// data/program RAMs, owning the RA0/WA0 D0 address registers. busy is the DSP T0 flag.
module scudsp_dma_seq #(
  parameter int unsigned AW = 27,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          st,
  input  logic          dir,
  input  logic [3:0]    ramw,
  input  logic          prgw,
  input  logic [1:0]    rams,
  input  logic [2:0]    addi,
  input  logic          hold,
  input  logic [CW-1:0] cnt,
  input  logic [31:0]   d1_data,
  input  logic          ra0_we,
  input  logic          wa0_we,
  output logic          d0_req,
  output logic          d0_we,
  output logic [AW-1:0] d0_addr,
  output logic [31:0]   d0_dout,
  input  logic [31:0]   d0_din,
  input  logic          d0_ack,
  output logic          ram_rd,
  input  logic [31:0]   ram_rdata,
  output logic [3:0]    ram_we,
  output logic          prg_we,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ct_inc,
  output logic          busy,
  output logic          done
);

  localparam int unsigned NW = CW + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D0RD    = 3'd1,
    RAMWR   = 3'd2,
    RAMRD   = 3'd3,
    RAMWAIT = 3'd4,
    D0WR    = 3'd5,
    FIN     = 3'd6
  } state_t;

  state_t        state, nxt_state;
  logic [AW-1:0] a, nxt_a;
  logic [NW-1:0] count, nxt_count;
  logic [AW-1:0] ra0, nxt_ra0;
  logic [AW-1:0] wa0, nxt_wa0;
  logic          dir_l, nxt_dir_l;
  logic [3:0]    ramw_l, nxt_ramw_l;
  logic          prgw_l, nxt_prgw_l;
  logic [1:0]    rams_l, nxt_rams_l;
  logic          hold_l, nxt_hold_l;
  logic [AW-1:0] inc_l, nxt_inc_l;
  logic [AW-1:0] inc_dec;
  logic          nxt_d0_req, nxt_d0_we, nxt_ram_rd, nxt_prg_we, nxt_busy, nxt_done;
  logic [31:0]   nxt_d0_dout, nxt_ram_wdata;
  logic [3:0]    nxt_ram_we, nxt_ct_inc;
  logic          ack_ok;
  logic          unused_d1;

  assign unused_d1 = ^{d1_data[31:AW+2], d1_data[1:0]};
  assign d0_addr   = a;
  assign ack_ok    = d0_ack & d0_req;
  // increment code 0 holds the address, codes 1..7 step by 2**(code-1) words
  assign inc_dec   = (addi == 3'd0) ? '0 : (AW'(1) << (addi - 3'd1));

  // next-state, datapath and registered-output decode
  always_comb begin
    nxt_state     = state;
    nxt_a         = a;
    nxt_count     = count;
    nxt_ra0       = ra0;
    nxt_wa0       = wa0;
    nxt_dir_l     = dir_l;
    nxt_ramw_l    = ramw_l;
    nxt_prgw_l    = prgw_l;
    nxt_rams_l    = rams_l;
    nxt_hold_l    = hold_l;
    nxt_inc_l     = inc_l;
    nxt_d0_dout   = d0_dout;
    nxt_ram_wdata = ram_wdata;

    case (state)
      IDLE: begin
        if (st) begin
          nxt_dir_l  = dir;
          nxt_ramw_l = ramw;
          nxt_prgw_l = prgw;
          nxt_rams_l = rams;
          nxt_hold_l = hold;
          nxt_inc_l  = inc_dec;
          nxt_a      = dir ? wa0 : ra0;
          nxt_count  = (cnt == '0) ? (NW'(1) << CW) : NW'(cnt);
          nxt_state  = dir ? RAMRD : D0RD;
        end
      end
      D0RD: begin
        if (ack_ok) begin
          nxt_ram_wdata = d0_din;
          nxt_state     = RAMWR;
        end
      end
      RAMWR: begin
        nxt_a     = a + inc_l;
        nxt_count = count - NW'(1);
        nxt_state = (count == NW'(1)) ? FIN : D0RD;
      end
      RAMRD: nxt_state = RAMWAIT;
      RAMWAIT: begin
        nxt_d0_dout = ram_rdata;
        nxt_state   = D0WR;
      end
      D0WR: begin
        if (ack_ok) begin
          nxt_a     = a + inc_l;
          nxt_count = count - NW'(1);
          nxt_state = (count == NW'(1)) ? FIN : RAMRD;
        end
      end
      FIN: begin
        if (!hold_l) begin
          if (dir_l) nxt_wa0 = a;
          else       nxt_ra0 = a;
        end
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase

    // D1 loads take priority over the end-of-transfer writeback
    if (ra0_we) nxt_ra0 = d1_data[AW+1:2];
    if (wa0_we) nxt_wa0 = d1_data[AW+1:2];

    nxt_d0_req = (nxt_state == D0RD) || (nxt_state == D0WR);
    nxt_d0_we  = (nxt_state == D0WR);
    nxt_ram_rd = (nxt_state == RAMRD);
    nxt_ram_we = (nxt_state == RAMWR) ? nxt_ramw_l : 4'd0;
    nxt_prg_we = (nxt_state == RAMWR) && nxt_prgw_l;
    nxt_ct_inc = (nxt_state == RAMWR) ? nxt_ramw_l :
                 (nxt_state == RAMRD) ? (4'(1) << nxt_rams_l) : 4'd0;
    nxt_busy   = (nxt_state != IDLE);
    nxt_done   = (nxt_state == FIN);
  end

  // state and output registers; strobes drop while the clock enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      count     <= '0;
      ra0       <= '0;
      wa0       <= '0;
      dir_l     <= 1'b0;
      ramw_l    <= '0;
      prgw_l    <= 1'b0;
      rams_l    <= '0;
      hold_l    <= 1'b0;
      inc_l     <= '0;
      d0_req    <= 1'b0;
      d0_we     <= 1'b0;
      d0_dout   <= '0;
      ram_rd    <= 1'b0;
      ram_we    <= '0;
      prg_we    <= 1'b0;
      ram_wdata <= '0;
      ct_inc    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (ce) begin
      state     <= nxt_state;
      a         <= nxt_a;
      count     <= nxt_count;
      ra0       <= nxt_ra0;
      wa0       <= nxt_wa0;
      dir_l     <= nxt_dir_l;
      ramw_l    <= nxt_ramw_l;
      prgw_l    <= nxt_prgw_l;
      rams_l    <= nxt_rams_l;
      hold_l    <= nxt_hold_l;
      inc_l     <= nxt_inc_l;
      d0_req    <= nxt_d0_req;
      d0_we     <= nxt_d0_we;
      d0_dout   <= nxt_d0_dout;
      ram_rd    <= nxt_ram_rd;
      ram_we    <= nxt_ram_we;
      prg_we    <= nxt_prg_we;
      ram_wdata <= nxt_ram_wdata;
      ct_inc    <= nxt_ct_inc;
      busy      <= nxt_busy;
      done      <= nxt_done;
    end else begin
      ram_rd <= 1'b0;
      ram_we <= '0;
      prg_we <= 1'b0;
      ct_inc <= '0;
      done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scudsp_dma_seq.sv
// Directed bench for scudsp_dma_seq: table of transfers plus hand-written
// sequences for FIN-cycle load, clock-enable hold and mid-transfer reset.
module tb_scudsp_dma_seq;

  logic        clk = 1'b0;
  logic        rst, ce, st, dir, prgw, hold, ra0_we, wa0_we, d0_ack;
  logic [3:0]  ramw;
  logic [1:0]  rams;
  logic [2:0]  addi;
  logic [7:0]  cnt;
  logic [31:0] d1_data, d0_din, ram_rdata;
  logic        d0_req, d0_we, ram_rd, prg_we, busy, done;
  logic [26:0] d0_addr;
  logic [31:0] d0_dout, ram_wdata;
  logic [3:0]  ram_we, ct_inc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scudsp_dma_seq #(.AW(27), .CW(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .st(st), .dir(dir), .ramw(ramw), .prgw(prgw),
    .rams(rams), .addi(addi), .hold(hold), .cnt(cnt), .d1_data(d1_data),
    .ra0_we(ra0_we), .wa0_we(wa0_we), .d0_req(d0_req), .d0_we(d0_we),
    .d0_addr(d0_addr), .d0_dout(d0_dout), .d0_din(d0_din), .d0_ack(d0_ack),
    .ram_rd(ram_rd), .ram_rdata(ram_rdata), .ram_we(ram_we), .prg_we(prg_we),
    .ram_wdata(ram_wdata), .ct_inc(ct_inc), .busy(busy), .done(done)
  );

  typedef struct {
    logic        dir;
    logic [3:0]  ramw;
    logic        prgw;
    logic [1:0]  rams;
    logic [2:0]  addi;
    logic        hold;
    logic [7:0]  cnt;
    logic [26:0] base;
    int          ack_dly;
    int          exp_words;
    logic [26:0] exp_reg;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rpat(input int k);
    return 32'h5A00_0000 ^ (32'(k) << 4);
  endfunction

  task automatic load_reg(input logic is_wa0, input logic [26:0] val);
    @(negedge clk);
    d1_data = {3'b000, val, 2'b00};
    ra0_we  = ~is_wa0;
    wa0_we  = is_wa0;
    @(negedge clk);
    ra0_we = 1'b0;
    wa0_we = 1'b0;
  endtask

  // one full transfer with a D0 responder, checking addresses, data, strobes and writeback
  task automatic run_xfer(input vec_t v, input bit extra_st, input bit fin_load);
    logic [26:0] inc, exp_a;
    int nreq = 0, nrd = 0, nwr = 0, ncts = 0, wt = 0, exp_cts;
    bit in_req = 0, got_done = 0;
    inc = (v.addi == 3'd0) ? 27'd0 : (27'(1) << (v.addi - 3'd1));
    exp_cts = (!v.dir && v.prgw) ? 0 : v.exp_words;
    load_reg(v.dir, v.base);
    st = 1'b1; dir = v.dir; ramw = v.ramw; prgw = v.prgw; rams = v.rams;
    addi = v.addi; hold = v.hold; cnt = v.cnt;
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      @(negedge clk);
      st = 1'b0; d0_ack = 1'b0; ra0_we = 1'b0;
      if (extra_st && cyc == 2) begin st = 1'b1; dir = ~v.dir; end
      if (cyc == 0) chk("busy_start", busy, 1);
      if (d0_req) begin
        exp_a = v.base + 27'(nreq) * inc;
        chk("d0_addr", d0_addr, exp_a);
        if (v.dir) chk("d0_dout", d0_dout, rpat(nreq));
        if (!in_req) begin
          chk("d0_we", d0_we, v.dir);
          in_req = 1; wt = 0;
        end
        if (wt == v.ack_dly) begin
          d0_ack = 1'b1; d0_din = 32'hA000_0000 | 32'(nreq);
          in_req = 0; nreq++;
        end else wt++;
      end
      if (ram_rd) begin ram_rdata = rpat(nrd); nrd++; end
      if (ct_inc != 4'd0) begin
        chk("ct_inc", ct_inc, v.dir ? (4'(1) << v.rams) : v.ramw);
        ncts++;
      end
      if (ram_we != 4'd0 || prg_we) begin
        chk("ram_we", ram_we, v.ramw);
        chk("prg_we", prg_we, v.prgw);
        chk("ram_wdata", ram_wdata, 32'hA000_0000 | 32'(nwr));
        nwr++;
      end
      if (done) begin
        got_done = 1;
        if (fin_load) begin d1_data = 32'h0000_0400; ra0_we = 1'b1; end
      end
    end
    chk("done_seen", got_done, 1);
    @(negedge clk);
    ra0_we = 1'b0;
    chk("busy_end", busy, 0);
    chk("done_pulse", done, 0);
    chk("d0_words", nreq, v.exp_words);
    chk("ram_words", v.dir ? nrd : nwr, v.exp_words);
    chk("ct_count", ncts, exp_cts);
    chk("final_reg", v.dir ? dut.wa0 : dut.ra0, v.exp_reg);
  endtask

  initial begin
    vec_t v5;
    int nwe;
    bit seen;
    rst = 1'b1; ce = 1'b1; st = 1'b0; dir = 1'b0; ramw = '0; prgw = 1'b0; rams = '0;
    addi = '0; hold = 1'b0; cnt = '0; d1_data = '0; ra0_we = 1'b0; wa0_we = 1'b0;
    d0_ack = 1'b0; d0_din = '0; ram_rdata = '0;

    //           dir  ramw  prgw rams addi hold cnt    base          dly words reg
    vecs[0] = '{1'b0, 4'b0001, 1'b0, 2'd0, 3'd1, 1'b0, 8'd3, 27'h100,     0, 3,   27'h103};
    vecs[1] = '{1'b1, 4'b0000, 1'b0, 2'd2, 3'd3, 1'b1, 8'd2, 27'h200,     5, 2,   27'h200};
    vecs[2] = '{1'b0, 4'b0000, 1'b1, 2'd0, 3'd1, 1'b0, 8'd0, 27'h000,     0, 256, 27'h100};
    vecs[3] = '{1'b0, 4'b0010, 1'b0, 2'd0, 3'd1, 1'b0, 8'd2, 27'h7FFFFFF, 0, 2,   27'h001};
    vecs[4] = '{1'b0, 4'b0100, 1'b0, 2'd0, 3'd0, 1'b0, 8'd4, 27'h050,     1, 4,   27'h050};
    vecs[5] = '{1'b1, 4'b0000, 1'b0, 2'd0, 3'd7, 1'b0, 8'd3, 27'h010,     2, 3,   27'h0D0};
    vecs[6] = '{1'b0, 4'b1000, 1'b0, 2'd0, 3'd2, 1'b1, 8'd2, 27'h300,     1, 2,   27'h300};

    repeat (3) @(negedge clk);
    chk("rst_req", d0_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_we", {ram_we, prg_we, ram_rd, ct_inc}, 0);
    chk("rst_ra0", dut.ra0, 0);
    rst = 1'b0;

    // stray ACK with no request pending
    @(negedge clk); d0_ack = 1'b1;
    @(negedge clk); d0_ack = 1'b0;
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_req", d0_req, 0);

    for (int i = 0; i < 7; i++) run_xfer(vecs[i], 1'b0, 1'b0);

    // second ST while busy is ignored; D1 load in the FIN cycle beats writeback
    v5 = '{1'b0, 4'b0001, 1'b0, 2'd0, 3'd1, 1'b0, 8'd2, 27'h020, 0, 2, 27'h100};
    run_xfer(v5, 1'b1, 1'b1);

    // clock enable low right after a RAM write must not re-fire the strobe
    load_reg(1'b0, 27'h030);
    st = 1'b1; dir = 1'b0; ramw = 4'b0001; prgw = 1'b0; addi = 3'd1; hold = 1'b0; cnt = 8'd1;
    nwe = 0; seen = 0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge clk);
      st = 1'b0; d0_ack = 1'b0;
      if (d0_req) begin d0_ack = 1'b1; d0_din = 32'hC0DE_0001; end
      if (ram_we != 4'd0) begin
        nwe++;
        ce = 1'b0;
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          chk("ce_hold_ram_we", ram_we, 0);
          chk("ce_hold_ct_inc", ct_inc, 0);
          chk("ce_hold_busy", busy, 1);
        end
        ce = 1'b1;
      end
      if (done) seen = 1;
    end
    chk("ce_done_seen", seen, 1);
    chk("ce_write_count", nwe, 1);
    @(negedge clk);
    chk("ce_final_ra0", dut.ra0, 27'h031);

    // reset while a request is outstanding
    load_reg(1'b0, 27'h040);
    st = 1'b1; dir = 1'b0; ramw = 4'b0001; addi = 3'd1; cnt = 8'd4;
    seen = 0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      st = 1'b0;
      if (d0_req) seen = 1;
    end
    chk("rst_req_seen", seen, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", d0_req, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done || d0_req) seen = 1;
    end
    chk("rst_no_done", seen, 0);
    chk("rst_ra0_cleared", dut.ra0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
